axi4_burst_sequencer: RTL and testbench

//  Expands one AXI4 burst command (AxADDR/AxLEN/AxSIZE/AxBURST/AxID) into per-beat addresses,

---
 rtl/axi4_burst_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_axi4_burst_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_sequencer.sv
// ---------------------------------------------------------------------------
// axi4_burst_sequencer
//   Expands one AXI4 burst command (addr/len/size/burst/id) into per-beat
//   byte addresses, byte strobes, beat index and a LAST flag using
//   FIXED / INCR / WRAP semantics. One beat per accepted beat handshake.
//
//   Optional feature macro: AXI4_BURST_CHECK_EN
//     defined   : commands are legality-checked at accept; illegal commands
//                 produce a one-cycle err_valid pulse (SLVERR) and no beats.
//     undefined : no checks; err_* outputs are tied to zero.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      burst command handshake
//   cmd_addr/len/size/burst  AxADDR / AxLEN / AxSIZE / AxBURST
//   cmd_id                   transaction ID, latched onto beat_id / err_id
//   beat_valid/beat_ready    beat descriptor handshake
//   beat_addr/strb/idx/last  per-beat address, byte lanes, index, final flag
//   beat_id                  latched command ID
//   err_valid/err_resp/err_id  rejected-command report
// ---------------------------------------------------------------------------
module axi4_burst_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [ID_W-1:0]       cmd_id,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_W-1:0]     beat_addr,
    output logic [DATA_W/8-1:0]   beat_strb,
    output logic [7:0]            beat_idx,
    output logic                  beat_last,
    output logic [ID_W-1:0]       beat_id,
    output logic                  err_valid,
    output logic [1:0]            err_resp,
    output logic [ID_W-1:0]       err_id
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned MAX_SIZE = $clog2(STRB_W);

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_type_t;

    typedef enum logic [2:0] {
        SIZE_1B   = 3'd0,
        SIZE_2B   = 3'd1,
        SIZE_4B   = 3'd2,
        SIZE_8B   = 3'd3,
        SIZE_16B  = 3'd4,
        SIZE_32B  = 3'd5,
        SIZE_64B  = 3'd6,
        SIZE_128B = 3'd7
    } burst_size_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [7:0]          len_q,   len_d;
    logic [7:0]          idx_q,   idx_d;
    burst_size_t         size_q,  size_d;
    burst_type_t         burst_q, burst_d;
    logic [ID_W-1:0]     id_q,    id_d;

    logic [2:0]          cmd_eff_size;
    logic                cmd_reject;

    logic [ADDR_W-1:0]   nb;
    logic [ADDR_W-1:0]   al;
    logic [ADDR_W-1:0]   incr_addr;
    logic [ADDR_W-1:0]   wrap_len_bytes;
    logic [ADDR_W-1:0]   wrap_lo;
    logic [ADDR_W-1:0]   next_addr;
    logic [31:0]         lane_lo;
    logic [31:0]         lane_hi;
    logic [STRB_W-1:0]   strb_calc;

    // Transfer size larger than the bus is clamped to the bus width.
    assign cmd_eff_size = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;

`ifdef AXI4_BURST_CHECK_EN
    logic [31:0] chk_nb;
    logic [31:0] chk_addr;
    logic [31:0] chk_span;
    logic        chk_wrap_len_ok;
    logic        chk_wrap_aligned;
    logic        chk_4k_cross;

    always_comb begin
        chk_nb           = 32'd1 << cmd_eff_size;
        chk_addr         = 32'(cmd_addr);
        // Byte span from the 4KB page offset of the aligned start to the end
        // of the last beat; beyond 4096 means the burst leaves the page.
        chk_span         = ((chk_addr & 32'hFFF) & ~(chk_nb - 32'd1))
                           + ((32'(cmd_len) + 32'd1) * chk_nb);
        chk_wrap_len_ok  = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                           (cmd_len == 8'd7) || (cmd_len == 8'd15);
        chk_wrap_aligned = ((chk_addr & (chk_nb - 32'd1)) == 32'd0);
        chk_4k_cross     = (chk_span > 32'd4096);
        cmd_reject       = (cmd_size > 3'(MAX_SIZE))
                        || (cmd_burst == BURST_RSVD)
                        || ((cmd_burst == BURST_WRAP) && (!chk_wrap_len_ok || !chk_wrap_aligned))
                        || ((cmd_burst == BURST_INCR) && chk_4k_cross);
    end
`else
    assign cmd_reject = 1'b0;
`endif

    // Address generation for the beat following the current one.
    always_comb begin
        nb             = ADDR_W'(1) << size_q;
        al             = addr_q & ~(nb - ADDR_W'(1));
        incr_addr      = al + nb;
        wrap_len_bytes = (ADDR_W'(len_q) + ADDR_W'(1)) << size_q;
        wrap_lo        = addr_q & ~(wrap_len_bytes - ADDR_W'(1));
        unique case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = (incr_addr == wrap_lo + wrap_len_bytes) ? wrap_lo : incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

    // Active lanes run from the byte the address points at up to the end of
    // the aligned nb-byte container, so an unaligned start covers only the tail.
    always_comb begin
        lane_lo   = 32'(addr_q & ADDR_W'(STRB_W - 1));
        lane_hi   = 32'(al & ADDR_W'(STRB_W - 1)) + (32'd1 << size_q);
        strb_calc = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            strb_calc[i] = (i >= lane_lo) && (i < lane_hi);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        size_d  = size_q;
        burst_d = burst_q;
        id_d    = id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    idx_d   = '0;
                    size_d  = burst_size_t'(cmd_eff_size);
                    burst_d = burst_type_t'(cmd_burst);
                    id_d    = cmd_id;
                    state_d = cmd_reject ? ST_ERR : ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_ready) begin
                    if (idx_q == len_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d = next_addr;
                        idx_d  = idx_q + 8'd1;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            size_q  <= SIZE_1B;
            burst_q <= BURST_FIXED;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            id_q    <= id_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign beat_valid = (state_q == ST_BURST);
    assign beat_addr  = addr_q;
    assign beat_strb  = beat_valid ? strb_calc : '0;
    assign beat_idx   = idx_q;
    assign beat_last  = beat_valid && (idx_q == len_q);
    assign beat_id    = id_q;

`ifdef AXI4_BURST_CHECK_EN
    assign err_valid = (state_q == ST_ERR);
    assign err_resp  = err_valid ? RESP_SLVERR : RESP_OKAY;
    assign err_id    = err_valid ? id_q : '0;
`else
    assign err_valid = 1'b0;
    assign err_resp  = RESP_OKAY;
    assign err_id    = '0;
`endif

endmodule

// File: tb/tb_axi4_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_axi4_burst_sequencer
//   Directed bench for axi4_burst_sequencer (default parameters). Expected
//   beats are pushed into a scoreboard queue when each command is issued and
//   popped as the DUT presents beats. Honours AXI4_BURST_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_axi4_burst_sequencer;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [7:0]  idx;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_id;
    logic        beat_valid;
    logic        beat_ready;
    logic [31:0] beat_addr;
    logic [3:0]  beat_strb;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic [3:0]  beat_id;
    logic        err_valid;
    logic [1:0]  err_resp;
    logic [3:0]  err_id;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    beat_t       exp_q[$];

    axi4_burst_sequencer #(
        .ADDR_W(32),
        .DATA_W(32),
        .ID_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .cmd_size(cmd_size),
        .cmd_burst(cmd_burst),
        .cmd_id(cmd_id),
        .beat_valid(beat_valid),
        .beat_ready(beat_ready),
        .beat_addr(beat_addr),
        .beat_strb(beat_strb),
        .beat_idx(beat_idx),
        .beat_last(beat_last),
        .beat_id(beat_id),
        .err_valid(err_valid),
        .err_resp(err_resp),
        .err_id(err_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] s, input logic [7:0] i,
                        input logic l, input logic [3:0] id);
        beat_t b;
        b.addr = a; b.strb = s; b.idx = i; b.last = l; b.id = id;
        exp_q.push_back(b);
    endtask

    task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id);
        int unsigned w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_before_issue", cmd_ready, 1);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        cmd_id    = id;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Consume beats until the expected LAST beat; optionally stall 3 cycles
    // on the beat whose index equals stall_idx.
    task automatic drain(input int stall_idx);
        int unsigned cyc;
        bit          first;
        beat_t       e;
        cyc   = 0;
        first = 1'b1;
        forever begin
            @(negedge clk);
            if (first) begin
                chk("first_beat_latency", beat_valid, 1);
                first = 1'b0;
            end
            if (beat_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", beat_valid, 0);
                    break;
                end
                e = exp_q[0];
                if (stall_idx >= 0 && beat_idx == 8'(stall_idx)) begin
                    beat_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        chk("stall_valid", beat_valid, 1);
                        chk("stall_addr", beat_addr, e.addr);
                        chk("stall_strb", beat_strb, e.strb);
                        chk("stall_idx", beat_idx, e.idx);
                    end
                    beat_ready = 1'b1;
                    stall_idx  = -1;
                end
                e = exp_q.pop_front();
                chk("beat_addr", beat_addr, e.addr);
                chk("beat_strb", beat_strb, e.strb);
                chk("beat_idx", beat_idx, e.idx);
                chk("beat_last", beat_last, e.last);
                chk("beat_id", beat_id, e.id);
                chk("err_quiet", err_valid, 0);
                if (e.last) break;
            end
            cyc++;
            if (cyc > 64) begin
                chk("drain_timeout_pending", exp_q.size(), 0);
                break;
            end
        end
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic expect_reject(input logic [3:0] id);
        @(negedge clk);
        chk("err_valid_pulse", err_valid, 1);
        chk("err_resp", err_resp, 2'b10);
        chk("err_id", err_id, id);
        chk("err_no_beat", beat_valid, 0);
        @(negedge clk);
        chk("err_valid_drop", err_valid, 0);
        chk("err_back_idle", cmd_ready, 1);
        chk("err_no_beat_after", beat_valid, 0);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_size   = '0;
        cmd_burst  = '0;
        cmd_id     = '0;
        beat_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_beat_valid", beat_valid, 0);
        chk("rst_beat_addr", beat_addr, 0);
        chk("rst_beat_strb", beat_strb, 0);
        chk("rst_beat_idx", beat_idx, 0);
        chk("rst_beat_last", beat_last, 0);
        chk("rst_beat_id", beat_id, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_resp", err_resp, 0);
        chk("rst_err_id", err_id, 0);
        rst = 1'b0;

        // INCR 4 beats of 4B
        push(32'h1000, 4'hF, 8'd0, 1'b0, 4'h1);
        push(32'h1004, 4'hF, 8'd1, 1'b0, 4'h1);
        push(32'h1008, 4'hF, 8'd2, 1'b0, 4'h1);
        push(32'h100C, 4'hF, 8'd3, 1'b1, 4'h1);
        issue(32'h1000, 8'd3, 3'd2, 2'b01, 4'h1);
        chk("busy_cmd_ready", cmd_ready, 0);
        drain(-1);
        @(negedge clk);
        chk("bubble_cmd_ready", cmd_ready, 1);
        chk("bubble_beat_valid", beat_valid, 0);

        // WRAP 4 beats of 4B starting mid-window
        push(32'h1008, 4'hF, 8'd0, 1'b0, 4'h2);
        push(32'h100C, 4'hF, 8'd1, 1'b0, 4'h2);
        push(32'h1000, 4'hF, 8'd2, 1'b0, 4'h2);
        push(32'h1004, 4'hF, 8'd3, 1'b1, 4'h2);
        issue(32'h1008, 8'd3, 3'd2, 2'b10, 4'h2);
        drain(-1);

        // FIXED 3 beats of 2B at 0x22
        push(32'h22, 4'hC, 8'd0, 1'b0, 4'h3);
        push(32'h22, 4'hC, 8'd1, 1'b0, 4'h3);
        push(32'h22, 4'hC, 8'd2, 1'b1, 4'h3);
        issue(32'h22, 8'd2, 3'd1, 2'b00, 4'h3);
        drain(-1);

        // Unaligned INCR start
        push(32'h1003, 4'h8, 8'd0, 1'b0, 4'hA);
        push(32'h1004, 4'hF, 8'd1, 1'b1, 4'hA);
        issue(32'h1003, 8'd1, 3'd2, 2'b01, 4'hA);
        drain(-1);

        // Single-beat burst
        push(32'h40, 4'hF, 8'd0, 1'b1, 4'h5);
        issue(32'h40, 8'd0, 3'd2, 2'b01, 4'h5);
        drain(-1);

        // Byte-sized INCR walks the lanes
        push(32'h5, 4'h2, 8'd0, 1'b0, 4'h4);
        push(32'h6, 4'h4, 8'd1, 1'b0, 4'h4);
        push(32'h7, 4'h8, 8'd2, 1'b1, 4'h4);
        issue(32'h5, 8'd2, 3'd0, 2'b01, 4'h4);
        drain(-1);

        // Back-pressure at idx 1
        push(32'h2000, 4'hF, 8'd0, 1'b0, 4'h6);
        push(32'h2004, 4'hF, 8'd1, 1'b0, 4'h6);
        push(32'h2008, 4'hF, 8'd2, 1'b0, 4'h6);
        push(32'h200C, 4'hF, 8'd3, 1'b1, 4'h6);
        issue(32'h2000, 8'd3, 3'd2, 2'b01, 4'h6);
        drain(1);

        // Reset in the middle of a burst
        issue(32'h3000, 8'd7, 3'd2, 2'b01, 4'h7);
        @(negedge clk);
        chk("midrst_beat0_valid", beat_valid, 1);
        chk("midrst_beat0_addr", beat_addr, 32'h3000);
        @(negedge clk);
        chk("midrst_beat1_addr", beat_addr, 32'h3004);
        rst = 1'b1;
        #1;
        chk("midrst_valid", beat_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_last", beat_last, 0);
        chk("midrst_idx", beat_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_no_beat", beat_valid, 0);
        end

`ifdef AXI4_BURST_CHECK_EN
        // INCR crossing 4KB
        issue(32'hFF8, 8'd3, 3'd2, 2'b01, 4'hB);
        expect_reject(4'hB);
        // Oversized transfer
        issue(32'h100, 8'd1, 3'd5, 2'b01, 4'h8);
        expect_reject(4'h8);
        // Reserved burst type
        issue(32'h200, 8'd1, 3'd2, 2'b11, 4'h9);
        expect_reject(4'h9);
        // WRAP with illegal length
        issue(32'h300, 8'd2, 3'd2, 2'b10, 4'hC);
        expect_reject(4'hC);
        // WRAP with unaligned start
        issue(32'h302, 8'd3, 3'd2, 2'b10, 4'hD);
        expect_reject(4'hD);
`else
        // Without checks the 4KB-crossing burst runs normally
        push(32'hFF8, 4'hF, 8'd0, 1'b0, 4'hB);
        push(32'hFFC, 4'hF, 8'd1, 1'b0, 4'hB);
        push(32'h1000, 4'hF, 8'd2, 1'b0, 4'hB);
        push(32'h1004, 4'hF, 8'd3, 1'b1, 4'hB);
        issue(32'hFF8, 8'd3, 3'd2, 2'b01, 4'hB);
        drain(-1);
        // Oversized transfer clamps to the 4B bus
        push(32'h100, 4'hF, 8'd0, 1'b0, 4'h8);
        push(32'h104, 4'hF, 8'd1, 1'b1, 4'h8);
        issue(32'h100, 8'd1, 3'd5, 2'b01, 4'h8);
        drain(-1);
        // Reserved burst type behaves as INCR
        push(32'h200, 4'hF, 8'd0, 1'b0, 4'h9);
        push(32'h204, 4'hF, 8'd1, 1'b1, 4'h9);
        issue(32'h200, 8'd1, 3'd2, 2'b11, 4'h9);
        drain(-1);
        @(negedge clk);
        chk("nocheck_err_valid", err_valid, 0);
        chk("nocheck_err_resp", err_resp, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
